// File: rtl/wb_bram_ctrl_pkg.sv
// Shared definitions for the Wishbone BRAM front-end: FSM encoding, window bases and hit decode.
package wb_bram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [11:0] BRAM_BASE_HI = 12'h380;
    localparam logic [11:0] UART_BASE_HI = 12'h300;

    // Holds MEM_LATENCY + WAIT_STATES, at most 4 + 7.
    localparam int CNT_W = 4;

    function automatic logic bram_hit(input logic cyc, input logic stb,
                                      input logic [11:0] adr_hi, input logic [11:0] base);
        return cyc & stb & (adr_hi == base);
    endfunction

endpackage

// File: rtl/wb_bram_ctrl_if.sv
// Wishbone classic slave bus as seen by the BRAM front-end.
interface wb_bram_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave front-end for a single-port BRAM: one strobe per transfer, counted latency,
// registered read data and a single-cycle ack. All outputs come straight from registers.
module wb_bram_ctrl
    import wb_bram_ctrl_pkg::*;
#(
    parameter logic [11:0] BASE_HI     = BRAM_BASE_HI,
    parameter int          ADDR_W      = 10,
    parameter int          MEM_LATENCY = 1,
    parameter int          WAIT_STATES = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_bram_ctrl_if.slave     wbs,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_dat_o,
    input  logic [31:0]       mem_dat_i
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY + WAIT_STATES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               wr_q, wr_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               en_q, en_d;
    logic [3:0]         we_q, we_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               hit;

    assign hit = bram_hit(wbs.wbs_cyc_i, wbs.wbs_stb_i, wbs.wbs_adr_i[31:20], BASE_HI);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        rdata_d = 32'h0;
        en_d    = 1'b0;
        we_d    = 4'h0;
        adr_d   = adr_q;
        wdat_d  = wdat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    adr_d   = wbs.wbs_adr_i[ADDR_W+1:2];
                    wdat_d  = wbs.wbs_dat_i;
                    wr_d    = wbs.wbs_we_i;
                    we_d    = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
                    en_d    = 1'b1;
                    abort_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                abort_d = abort_q | ~wbs.wbs_cyc_i;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                abort_d = abort_q | ~wbs.wbs_cyc_i;
                // An abandoned transfer still runs out its count so the issued access completes.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = abort_d ? ST_IDLE : ST_ACK;
                    ack_d   = ~abort_d;
                    rdata_d = (abort_d || wr_q) ? 32'h0 : mem_dat_i;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            adr_q   <= '0;
            wdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdata_q;
    assign mem_en_o      = en_q;
    assign mem_we_o      = we_q;
    assign mem_adr_o     = adr_q;
    assign mem_dat_o     = wdat_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: default-latency instance A and a slow instance B
// (latency 3, 2 wait states), each with a byte-lane BRAM model behind it.
module tb_wb_bram_ctrl;

    typedef struct {
        int          ack_cyc;
        int          ack_cnt;
        int          en_cyc;
        int          en_cnt;
        logic [31:0] rdat;
        logic [3:0]  en_we;
        logic [9:0]  en_adr;
        logic [31:0] en_dat;
        logic [31:0] dat_c2;
        logic [31:0] dat_c4;
        logic        zero_after_rst;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        tgt_b;
    logic        drv_cyc, drv_stb, drv_we;
    logic [3:0]  drv_sel;
    logic [31:0] drv_dat, drv_adr;

    int checks = 0;
    int errors = 0;

    wb_bram_ctrl_if wa ();
    wb_bram_ctrl_if wbi ();

    logic        ma_en, mb_en;
    logic [3:0]  ma_we, mb_we;
    logic [9:0]  ma_adr, mb_adr;
    logic [31:0] ma_wd, mb_wd;
    logic [31:0] rd_a, pb0, pb1, pb2;
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    assign wa.wbs_cyc_i  = drv_cyc & ~tgt_b;
    assign wa.wbs_stb_i  = drv_stb & ~tgt_b;
    assign wa.wbs_we_i   = drv_we;
    assign wa.wbs_sel_i  = drv_sel;
    assign wa.wbs_dat_i  = drv_dat;
    assign wa.wbs_adr_i  = drv_adr;
    assign wbi.wbs_cyc_i = drv_cyc & tgt_b;
    assign wbi.wbs_stb_i = drv_stb & tgt_b;
    assign wbi.wbs_we_i  = drv_we;
    assign wbi.wbs_sel_i = drv_sel;
    assign wbi.wbs_dat_i = drv_dat;
    assign wbi.wbs_adr_i = drv_adr;

    wb_bram_ctrl u_dut_a (
        .wb_clk_i (clk), .wb_rst_i (rst), .wbs (wa.slave),
        .mem_en_o (ma_en), .mem_we_o (ma_we), .mem_adr_o (ma_adr),
        .mem_dat_o (ma_wd), .mem_dat_i (rd_a)
    );

    wb_bram_ctrl #(.MEM_LATENCY(3), .WAIT_STATES(2)) u_dut_b (
        .wb_clk_i (clk), .wb_rst_i (rst), .wbs (wbi.slave),
        .mem_en_o (mb_en), .mem_we_o (mb_we), .mem_adr_o (mb_adr),
        .mem_dat_o (mb_wd), .mem_dat_i (pb2)
    );

    logic        obs_ack, obs_en;
    logic [31:0] obs_dat, obs_mdat;
    logic [3:0]  obs_we;
    logic [9:0]  obs_madr;
    assign obs_ack  = tgt_b ? wbi.wbs_ack_o : wa.wbs_ack_o;
    assign obs_dat  = tgt_b ? wbi.wbs_dat_o : wa.wbs_dat_o;
    assign obs_en   = tgt_b ? mb_en  : ma_en;
    assign obs_we   = tgt_b ? mb_we  : ma_we;
    assign obs_madr = tgt_b ? mb_adr : ma_adr;
    assign obs_mdat = tgt_b ? mb_wd  : ma_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= 32'hA5A5_0000 | 32'(i);
            mem_b[i] <= 32'hA5A5_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        if (ma_en) begin
            for (int b = 0; b < 4; b++)
                if (ma_we[b]) mem_a[ma_adr][8*b +: 8] <= ma_wd[8*b +: 8];
            rd_a <= mem_a[ma_adr];
        end
        if (mb_en) begin
            for (int b = 0; b < 4; b++)
                if (mb_we[b]) mem_b[mb_adr][8*b +: 8] <= mb_wd[8*b +: 8];
            pb0 <= mem_b[mb_adr];
        end
        pb1 <= pb0;
        pb2 <= pb1;
    end

    task automatic bus_idle();
        drv_cyc = 1'b0; drv_stb = 1'b0; drv_we = 1'b0;
        drv_sel = 4'h0; drv_dat = 32'h0; drv_adr = 32'h0;
    endtask

    // Runs one request from C0 for ncyc cycles; drop_cyc/rst_cyc < 0 disable those events.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input logic stb, input int ncyc,
                        input int drop_cyc, input int rst_cyc, output obs_t o);
        logic acked;
        o.ack_cyc = -1; o.ack_cnt = 0; o.en_cyc = -1; o.en_cnt = 0;
        o.rdat = 32'h0; o.en_we = 4'h0; o.en_adr = 10'h0; o.en_dat = 32'h0;
        o.dat_c2 = 32'hFFFF_FFFF; o.dat_c4 = 32'hFFFF_FFFF; o.zero_after_rst = 1'b0;
        @(posedge clk); #1;
        drv_adr = adr; drv_we = we; drv_sel = sel; drv_dat = dat; drv_cyc = 1'b1; drv_stb = stb;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acked = obs_ack;
            if (obs_ack) begin
                o.ack_cnt++;
                if (o.ack_cyc < 0) begin o.ack_cyc = c; o.rdat = obs_dat; end
            end
            if (obs_en) begin
                o.en_cnt++;
                if (o.en_cyc < 0) begin
                    o.en_cyc = c; o.en_we = obs_we; o.en_adr = obs_madr; o.en_dat = obs_mdat;
                end
            end
            if (c == 2) o.dat_c2 = obs_dat;
            if (c == 4) o.dat_c4 = obs_dat;
            if (rst_cyc >= 0 && c == rst_cyc + 1)
                o.zero_after_rst = (obs_ack === 1'b0) && (obs_dat === 32'h0) && (obs_en === 1'b0)
                                   && (obs_we === 4'h0) && (obs_madr === 10'h0) && (obs_mdat === 32'h0);
            @(posedge clk); #1;
            if (acked || c + 1 == drop_cyc) bus_idle();
            if (c + 1 == rst_cyc) begin rst = 1'b1; bus_idle(); end
            else rst = 1'b0;
        end
        bus_idle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tgt_b = 1'b0; bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wa.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", wa.wbs_ack_o); end
        checks++; if (wa.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", wa.wbs_dat_o); end
        checks++; if (ma_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", ma_en); end
        checks++; if (ma_we !== 4'h0) begin errors++; $display("FAIL rst_we got %h exp 0", ma_we); end
        checks++; if (ma_adr !== 10'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", ma_adr); end
        checks++; if (ma_wd !== 32'h0) begin errors++; $display("FAIL rst_wdat got %h exp 0", ma_wd); end
        checks++; if (wbi.wbs_ack_o !== 1'b0 || mb_en !== 1'b0) begin errors++; $display("FAIL rst_b got ack=%b en=%b exp 0", wbi.wbs_ack_o, mb_en); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_write();
        obs_t o;
        xfer(32'h3800_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 6, -1, -1, o);
        checks++; if (o.en_cyc !== 1) begin errors++; $display("FAIL wr_en_cyc got %0d exp 1", o.en_cyc); end
        checks++; if (o.en_cnt !== 1) begin errors++; $display("FAIL wr_en_cnt got %0d exp 1", o.en_cnt); end
        checks++; if (o.en_adr !== 10'd4) begin errors++; $display("FAIL wr_adr got %h exp 004", o.en_adr); end
        checks++; if (o.en_we !== 4'hF) begin errors++; $display("FAIL wr_we got %h exp f", o.en_we); end
        checks++; if (o.en_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_dat got %h exp deadbeef", o.en_dat); end
        checks++; if (o.ack_cyc !== 3) begin errors++; $display("FAIL wr_ack_cyc got %0d exp 3", o.ack_cyc); end
        checks++; if (o.ack_cnt !== 1) begin errors++; $display("FAIL wr_ack_cnt got %0d exp 1", o.ack_cnt); end
    endtask

    task automatic test_read();
        obs_t o;
        xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.ack_cyc !== 3) begin errors++; $display("FAIL rd_ack_cyc got %0d exp 3", o.ack_cyc); end
        checks++; if (o.rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_dat got %h exp deadbeef", o.rdat); end
        checks++; if (o.dat_c2 !== 32'h0) begin errors++; $display("FAIL rd_dat_c2 got %h exp 0", o.dat_c2); end
        checks++; if (o.dat_c4 !== 32'h0) begin errors++; $display("FAIL rd_dat_c4 got %h exp 0", o.dat_c4); end
        checks++; if (o.en_we !== 4'h0) begin errors++; $display("FAIL rd_we got %h exp 0", o.en_we); end
    endtask

    task automatic test_byte_write();
        obs_t o;
        xfer(32'h3800_0010, 1'b1, 4'b0010, 32'h0000_AB00, 1'b1, 6, -1, -1, o);
        checks++; if (o.en_we !== 4'b0010) begin errors++; $display("FAIL bw_we got %h exp 2", o.en_we); end
        xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.rdat !== 32'hDEAD_ABEF) begin errors++; $display("FAIL bw_rd got %h exp deadabef", o.rdat); end
        // sel=0 write: strobe with no lanes, still acked, memory unchanged.
        xfer(32'h3800_0010, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, 6, -1, -1, o);
        checks++; if (o.en_cnt !== 1 || o.en_we !== 4'h0) begin errors++; $display("FAIL sel0_en got cnt=%0d we=%h exp 1/0", o.en_cnt, o.en_we); end
        checks++; if (o.ack_cyc !== 3) begin errors++; $display("FAIL sel0_ack got %0d exp 3", o.ack_cyc); end
        xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.rdat !== 32'hDEAD_ABEF) begin errors++; $display("FAIL sel0_rd got %h exp deadabef", o.rdat); end
    endtask

    task automatic test_wrap();
        obs_t o;
        xfer(32'h3800_1018, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 6, -1, -1, o);
        checks++; if (o.en_adr !== 10'd6) begin errors++; $display("FAIL wrap_adr got %h exp 006", o.en_adr); end
        xfer(32'h3800_0018, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.rdat !== 32'h1122_3344) begin errors++; $display("FAIL wrap_rd got %h exp 11223344", o.rdat); end
    endtask

    task automatic test_miss();
        obs_t o;
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 20, -1, -1, o);
        checks++; if (o.en_cnt !== 0) begin errors++; $display("FAIL uart_en got %0d exp 0", o.en_cnt); end
        checks++; if (o.ack_cnt !== 0) begin errors++; $display("FAIL uart_ack got %0d exp 0", o.ack_cnt); end
        xfer(32'h3800_0000, 1'b0, 4'hF, 32'h0, 1'b0, 20, -1, -1, o);
        checks++; if (o.en_cnt !== 0) begin errors++; $display("FAIL nostb_en got %0d exp 0", o.en_cnt); end
        checks++; if (o.ack_cnt !== 0) begin errors++; $display("FAIL nostb_ack got %0d exp 0", o.ack_cnt); end
    endtask

    task automatic test_back_to_back();
        int          ack_c[$];
        int          en_c[$];
        logic [31:0] rd[$];
        logic        acked;
        @(posedge clk); #1;
        drv_adr = 32'h3800_0010; drv_we = 1'b0; drv_sel = 4'hF; drv_cyc = 1'b1; drv_stb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acked = wa.wbs_ack_o;
            if (wa.wbs_ack_o) begin ack_c.push_back(c); rd.push_back(wa.wbs_dat_o); end
            if (ma_en) en_c.push_back(c);
            @(posedge clk); #1;
            if (acked) begin
                if (ack_c.size() == 1) drv_adr = 32'h3800_0014;
                else bus_idle();
            end
        end
        bus_idle();
        checks++; if (ack_c.size() !== 2) begin errors++; $display("FAIL b2b_acks got %0d exp 2", ack_c.size()); end
        checks++; if (en_c.size() !== 2) begin errors++; $display("FAIL b2b_ens got %0d exp 2", en_c.size()); end
        if (ack_c.size() == 2 && en_c.size() == 2) begin
            checks++; if (en_c[1] !== 5) begin errors++; $display("FAIL b2b_en2 got %0d exp 5", en_c[1]); end
            checks++; if (ack_c[0] !== 3 || ack_c[1] !== 7) begin errors++; $display("FAIL b2b_ack_cyc got %0d,%0d exp 3,7", ack_c[0], ack_c[1]); end
            checks++; if (rd[0] !== 32'hDEAD_ABEF) begin errors++; $display("FAIL b2b_rd1 got %h exp deadabef", rd[0]); end
            checks++; if (rd[1] !== 32'hA5A5_0005) begin errors++; $display("FAIL b2b_rd2 got %h exp a5a50005", rd[1]); end
        end
    endtask

    task automatic test_abort_write();
        obs_t o;
        xfer(32'h3800_0030, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 8, 2, -1, o);
        checks++; if (o.ack_cnt !== 0) begin errors++; $display("FAIL abw_ack got %0d exp 0", o.ack_cnt); end
        checks++; if (o.en_cnt !== 1) begin errors++; $display("FAIL abw_en got %0d exp 1", o.en_cnt); end
        xfer(32'h3800_0030, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.rdat !== 32'h1234_5678 || o.ack_cyc !== 3) begin errors++; $display("FAIL abw_rd got %h@%0d exp 12345678@3", o.rdat, o.ack_cyc); end
    endtask

    task automatic test_latency();
        obs_t o;
        tgt_b = 1'b1;
        xfer(32'h3800_0020, 1'b0, 4'hF, 32'h0, 1'b1, 10, -1, -1, o);
        checks++; if (o.ack_cyc !== 7) begin errors++; $display("FAIL lat_ack_cyc got %0d exp 7", o.ack_cyc); end
        checks++; if (o.ack_cnt !== 1) begin errors++; $display("FAIL lat_ack_cnt got %0d exp 1", o.ack_cnt); end
        checks++; if (o.en_cyc !== 1 || o.en_cnt !== 1) begin errors++; $display("FAIL lat_en got %0d@%0d exp 1@1", o.en_cnt, o.en_cyc); end
        checks++; if (o.rdat !== 32'hA5A5_0008) begin errors++; $display("FAIL lat_rd got %h exp a5a50008", o.rdat); end
        checks++; if (o.dat_c4 !== 32'h0) begin errors++; $display("FAIL lat_dat_c4 got %h exp 0", o.dat_c4); end
        xfer(32'h3800_0024, 1'b0, 4'hF, 32'h0, 1'b1, 8, 3, -1, o);
        checks++; if (o.ack_cnt !== 0) begin errors++; $display("FAIL lat_abort_ack got %0d exp 0", o.ack_cnt); end
        checks++; if (o.en_cnt !== 1) begin errors++; $display("FAIL lat_abort_en got %0d exp 1", o.en_cnt); end
        xfer(32'h3800_0028, 1'b0, 4'hF, 32'h0, 1'b1, 10, -1, -1, o);
        checks++; if (o.ack_cyc !== 7 || o.rdat !== 32'hA5A5_000A) begin errors++; $display("FAIL lat_after got %h@%0d exp a5a5000a@7", o.rdat, o.ack_cyc); end
        tgt_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        xfer(32'h3800_0008, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 8, -1, 2, o);
        checks++; if (o.zero_after_rst !== 1'b1) begin errors++; $display("FAIL rstmid_zero got %b exp 1", o.zero_after_rst); end
        checks++; if (o.ack_cnt !== 0) begin errors++; $display("FAIL rstmid_ack got %0d exp 0", o.ack_cnt); end
        xfer(32'h3800_0004, 1'b0, 4'hF, 32'h0, 1'b1, 6, -1, -1, o);
        checks++; if (o.ack_cyc !== 3 || o.ack_cnt !== 1) begin errors++; $display("FAIL rstmid_rd_ack got %0d@%0d exp 1@3", o.ack_cnt, o.ack_cyc); end
        checks++; if (o.rdat !== 32'hA5A5_0001) begin errors++; $display("FAIL rstmid_rd got %h exp a5a50001", o.rdat); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_wrap();
        test_miss();
        test_back_to_back();
        test_abort_write();
        test_latency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
